// File: rtl/fb_scanout_reader.sv
// Fetches 4-bit pixel indices in raster order into a FWFT FIFO and serves them as a valid/ready stream.
// A pixel is visible RD_LAT+1 edges after its read; reads stall once FIFO entries plus in-flight reads reach FIFO_DEPTH.
module fb_scanout_reader #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  output logic [19:0] fb_r_addr,
  output logic        fb_read,
  input  logic [3:0]  fb_rdata,
  output logic [3:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        underflow
);

  localparam logic [19:0] LAST_ADDR = 20'(H_RES * V_RES - 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t            state_q, state_d;
  logic [19:0]       addr_q, addr_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              underflow_q, underflow_d;
  logic [3:0]        fifo_mem [FIFO_DEPTH];
  logic [IW-1:0]     inflight;
  logic              push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(tag_q[i]);
  end

  // Credit check ignores a same-cycle pop on purpose: simpler and still never overflows.
  assign fb_read    = (state_q == FETCH) && !frame_start &&
                      ((int'(count_q) + int'(inflight)) < FIFO_DEPTH);
  assign fb_r_addr  = addr_q;
  assign frame_done = fb_read && (addr_q == LAST_ADDR);
  assign push       = tag_q[RD_LAT-1];
  assign pix_valid  = (count_q != '0);
  assign pop        = pix_valid && pix_ready;
  assign pix_data   = pix_valid ? fifo_mem[rd_ptr_q] : 4'd0;
  assign underflow  = underflow_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (frame_start) begin
      state_d     = FETCH;
      addr_d      = '0;
      tag_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      tag_d = (tag_q << 1) | RD_LAT'(fb_read);
      if (fb_read) begin
        if (addr_q == LAST_ADDR) state_d = DONE;
        else                     addr_d  = addr_q + 20'd1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if ((state_q == FETCH) && pix_ready && !pix_valid) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !frame_start) fifo_mem[wr_ptr_q] <= fb_rdata;
  end

  a_no_overflow: assert property (@(posedge Clk) disable iff (!Reset_n)
    !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: two instances (RD_LAT 2 on a small frame, RD_LAT 4 at full size)
// checked every cycle against a counting model of reads, returns and pops.
module tb_fb_scanout_reader;

  localparam int DEPTH = 16;
  localparam int LAT0  = 2;
  localparam int LAT1  = 4;
  localparam int LAST0 = 40 * 30 - 1;
  localparam int LAST1 = 640 * 480 - 1;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        fs0, rdy0, fs1, rdy1;
  logic [3:0]  rdata0, rdata1, pd0, pd1;
  logic [19:0] addr0, addr1;
  logic        rd0, rd1, pv0, pv1, dn0, dn1, uf0, uf1;

  int checks = 0;
  int errors = 0;
  int issued[2], popped[2], returned[2], nreads[2];
  logic fetch_m[2], uf_m[2];
  logic mv[2][4], lv[2][4];
  logic [19:0] ma[2][4];
  logic last_pv0, last_dn0;
  logic [19:0] last_ad0;

  always #5 Clk = ~Clk;

  fb_scanout_reader #(.H_RES(40), .V_RES(30), .RD_LAT(LAT0), .FIFO_DEPTH(DEPTH)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(fs0), .fb_r_addr(addr0), .fb_read(rd0),
    .fb_rdata(rdata0), .pix_data(pd0), .pix_valid(pv0), .pix_ready(rdy0),
    .frame_done(dn0), .underflow(uf0));

  fb_scanout_reader #(.H_RES(640), .V_RES(480), .RD_LAT(LAT1), .FIFO_DEPTH(DEPTH)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(fs1), .fb_r_addr(addr1), .fb_read(rd1),
    .fb_rdata(rdata1), .pix_data(pd1), .pix_valid(pv1), .pix_ready(rdy1),
    .frame_done(dn1), .underflow(uf1));

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int last_of(input int i);
    return (i == 0) ? LAST0 : LAST1;
  endfunction

  // Framebuffer content: each location holds the low nibble of its address.
  function automatic logic [3:0] dat(input int a);
    logic [31:0] v;
    v = a;
    return v[3:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_0"}, 32'({rd0, pv0, dn0, uf0, pd0, addr0}), 32'd0);
    chk({tag, "_1"}, 32'({rd1, pv1, dn1, uf1, pd1, addr1}), 32'd0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      issued[i] = 0; popped[i] = 0; returned[i] = 0; nreads[i] = 0;
      fetch_m[i] = 1'b0; uf_m[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mv[i][k] = 1'b0; lv[i][k] = 1'b0; ma[i][k] = '0;
      end
    end
  endtask

  task automatic reset_cycle(input string tag);
    fs0 = 1'($urandom); fs1 = 1'($urandom);
    rdy0 = 1'($urandom); rdy1 = 1'($urandom);
    rdata0 = 4'($urandom); rdata1 = 4'($urandom);
    @(posedge Clk);
    #1;
    chk_zero(tag);
  endtask

  // One clock: compare pre-edge outputs with the model, then advance model and memory.
  task automatic tick();
    logic o_rd[2], o_dn[2], o_pv[2], o_uf[2], i_fs[2], i_rdy[2];
    logic [19:0] o_ad[2];
    logic [3:0] o_pd[2];
    logic e_pv[2], e_rd[2], e_dn[2], push[2];
    int l;
    #1;
    o_rd[0] = rd0;  o_rd[1] = rd1;  o_dn[0] = dn0;  o_dn[1] = dn1;
    o_pv[0] = pv0;  o_pv[1] = pv1;  o_uf[0] = uf0;  o_uf[1] = uf1;
    o_ad[0] = addr0; o_ad[1] = addr1; o_pd[0] = pd0; o_pd[1] = pd1;
    i_fs[0] = fs0;  i_fs[1] = fs1;  i_rdy[0] = rdy0; i_rdy[1] = rdy1;
    for (int i = 0; i < 2; i++) begin
      e_pv[i] = (returned[i] - popped[i]) > 0;
      e_rd[i] = fetch_m[i] && !i_fs[i] && ((issued[i] - popped[i]) < DEPTH);
      e_dn[i] = e_rd[i] && (issued[i] == last_of(i));
      chk($sformatf("pix_valid%0d", i), 32'(o_pv[i]), 32'(e_pv[i]));
      chk($sformatf("fb_read%0d", i), 32'(o_rd[i]), 32'(e_rd[i]));
      chk($sformatf("frame_done%0d", i), 32'(o_dn[i]), 32'(e_dn[i]));
      chk($sformatf("underflow%0d", i), 32'(o_uf[i]), 32'(uf_m[i]));
      chk($sformatf("pix_data%0d", i), 32'(o_pd[i]), e_pv[i] ? 32'(dat(popped[i])) : 32'd0);
      if (e_rd[i]) chk($sformatf("fb_r_addr%0d", i), 32'(o_ad[i]), 32'(issued[i]));
      nreads[i] += int'(o_rd[i]);
    end
    last_pv0 = o_pv[0]; last_dn0 = o_dn[0]; last_ad0 = o_ad[0];
    @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      l = lat_of(i);
      push[i] = mv[i][l-1] && lv[i][l-1];
      if (i_fs[i]) begin
        issued[i] = 0; popped[i] = 0; returned[i] = 0;
        fetch_m[i] = 1'b1; uf_m[i] = 1'b0;
      end else begin
        if (fetch_m[i] && i_rdy[i] && !e_pv[i]) uf_m[i] = 1'b1;
        if (e_rd[i]) issued[i]++;
        if (e_dn[i]) fetch_m[i] = 1'b0;
        if (e_pv[i] && i_rdy[i]) popped[i]++;
        if (push[i]) returned[i]++;
      end
      for (int k = 3; k > 0; k--) begin
        mv[i][k] = mv[i][k-1]; lv[i][k] = lv[i][k-1]; ma[i][k] = ma[i][k-1];
      end
      mv[i][0] = o_rd[i]; lv[i][0] = o_rd[i]; ma[i][0] = o_ad[i];
      if (i_fs[i]) for (int k = 0; k < 4; k++) lv[i][k] = 1'b0;
    end
    rdata0 = mv[0][LAT0-1] ? ma[0][LAT0-1][3:0] : 4'($urandom);
    rdata1 = mv[1][LAT1-1] ? ma[1][LAT1-1][3:0] : 4'($urandom);
  endtask

  initial begin
    int n, gaps, r0;
    logic seen;
    Reset_n = 1'b0;
    fs0 = 1'b0; fs1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0; rdata0 = '0; rdata1 = '0;
    reset_model();
    #1;
    for (int c = 0; c < 5; c++) reset_cycle("reset");

    // Release: IDLE must not read or flag underflow whatever pix_ready does.
    fs0 = 1'b0; fs1 = 1'b0; Reset_n = 1'b1;
    reset_model();
    for (int c = 0; c < 6; c++) begin
      rdy0 = 1'($urandom); rdy1 = 1'($urandom); tick();
    end

    // Fill with no consumer.
    rdy0 = 1'b0; rdy1 = 1'b0; nreads[0] = 0;
    fs0 = 1'b1; tick(); fs0 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == LAT0 + 1) chk("fill_pv_before", 32'(last_pv0), 32'd0);
      if (k == LAT0 + 2) chk("fill_pv_rise", 32'(last_pv0), 32'd1);
    end
    chk("fill_reads", 32'(nreads[0]), 32'd16);
    chk("fill_addr", 32'(addr0), 32'd16);

    // Continuous streaming.
    rdy0 = 1'b1; gaps = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!last_pv0) gaps++;
    end
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_underflow", 32'(uf0), 32'd0);

    // Random consumer.
    for (int k = 0; k < 300; k++) begin
      rdy0 = ($urandom_range(0, 3) != 0); rdy1 = 1'($urandom); tick();
    end
    chk("random_underflow", 32'(uf0), 32'd0);

    // Mid-frame restart while reads are in flight.
    rdy0 = 1'b1; n = 0;
    while (addr0 != 20'd1000 && n < 3000) begin tick(); n++; end
    chk("restart_reach", 32'(addr0), 32'd1000);
    fs0 = 1'b1; tick(); fs0 = 1'b0; rdy0 = 1'b0;
    chk("restart_pv", 32'(pv0), 32'd0);
    chk("restart_addr", 32'(addr0), 32'd0);
    n = 0;
    while (!pv0 && n < 20) begin tick(); n++; end
    chk("restart_first_valid", 32'(pv0), 32'd1);
    chk("restart_first_pix", 32'(pd0), 32'd0);

    // Run to the end of the frame.
    seen = 1'b0; n = 0;
    while (!seen && n < 5000) begin
      rdy0 = ($urandom_range(0, 3) != 0); rdy1 = 1'($urandom);
      tick(); n++;
      if (last_dn0) begin
        seen = 1'b1;
        chk("done_addr", 32'(last_ad0), 32'(LAST0));
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    rdy0 = 1'b1; r0 = nreads[0];
    for (int k = 0; k < 40; k++) tick();
    chk("done_no_reads", 32'(nreads[0] - r0), 32'd0);
    chk("done_drained", 32'(pv0), 32'd0);
    chk("done_underflow", 32'(uf0), 32'd0);

    // Deep latency: startup gap with an eager consumer sets the sticky flag.
    rdy1 = 1'b1; fs1 = 1'b1; tick(); fs1 = 1'b0; tick();
    chk("uf_set", 32'(uf1), 32'd1);
    for (int k = 0; k < 100; k++) tick();
    chk("uf_sticky", 32'(uf1), 32'd1);
    chk("uf_streaming", 32'(pv1), 32'd1);
    rdy1 = 1'b0; fs1 = 1'b1; tick(); fs1 = 1'b0;
    chk("uf_cleared", 32'(uf1), 32'd0);
    for (int k = 0; k < 10; k++) tick();
    chk("uf_stays_clear", 32'(uf1), 32'd0);

    // Asynchronous reset in mid-frame, then a fresh frame.
    rdy0 = 1'b0; fs0 = 1'b1; tick(); fs0 = 1'b0;
    for (int k = 0; k < 20; k++) begin rdy0 = 1'($urandom); tick(); end
    Reset_n = 1'b0;
    #1;
    chk_zero("midreset_async");
    for (int c = 0; c < 3; c++) reset_cycle("midreset");
    fs0 = 1'b0; fs1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0; Reset_n = 1'b1;
    reset_model();
    for (int c = 0; c < 3; c++) tick();
    fs0 = 1'b1; tick(); fs0 = 1'b0;
    for (int k = 0; k < 60; k++) begin rdy0 = ($urandom_range(0, 3) != 0); tick(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
